// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with show-ahead FIFO; define UART_RX_PARITY_EN for 8E1 with even-parity checking
module uart_receiver #(
  parameter int clks_per_bit_p = 5208,
  parameter int fifo_depth_p = 16
) (
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic       Rx_i,
  input  logic       Rd_En_i,
  output logic [7:0] Data_o,
  output logic       Data_Available_o,
  output logic       Frame_Error_o,
  output logic       Overflow_o,
  output logic       Parity_Error_o
);
  localparam int cw = $clog2(clks_per_bit_p);
  localparam int aw = $clog2(fifo_depth_p);
  localparam int aw1 = aw + 1;
  localparam logic [cw-1:0] bit_reload = cw'(clks_per_bit_p - 1);
  localparam logic [cw-1:0] half_reload = cw'(clks_per_bit_p / 2 - 1);
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP, WAIT_HIGH
  } state_t;
  state_t state, state_n;
  logic rx_meta, rx_s;
  logic [cw-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic push, fe_n, ov_n, expire, pop, wr;
  logic [7:0] mem [fifo_depth_p];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [aw:0] count;
`ifdef UART_RX_PARITY_EN
  logic par_ok, par_ok_n, pe_n;
`endif
  assign expire = cnt == '0;
  assign pop = Rd_En_i && count != '0;
  assign wr = push && (!count[aw] || pop);
  assign ov_n = push && count[aw] && !pop;
  assign Data_Available_o = count != '0;
  assign Data_o = count != '0 ? mem[rd_ptr] : 8'h00;
`ifndef UART_RX_PARITY_EN
  assign Parity_Error_o = 1'b0;
`endif
  // Two-flop synchroniser for the asynchronous serial input, idling high
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      rx_meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_meta <= Rx_i;
      rx_s <= rx_meta;
    end
  end
  // Receiver state, bit timer, shift register and registered flag pulses
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      Frame_Error_o <= 1'b0;
      Overflow_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok <= 1'b0;
      Parity_Error_o <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      Frame_Error_o <= fe_n;
      Overflow_o <= ov_n;
`ifdef UART_RX_PARITY_EN
      par_ok <= par_ok_n;
      Parity_Error_o <= pe_n;
`endif
    end
  end
  // Frame sequencing: each bit is sampled when the timer expires, then the timer reloads
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    sh_n = sh;
    push = 1'b0;
    fe_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ok_n = par_ok;
    pe_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = half_reload;
        state_n = rx_s ? IDLE : START;
      end
      START: begin
        cnt_n = expire ? bit_reload : cnt - cw'(1);
        idx_n = '0;
        if (expire) state_n = rx_s ? IDLE : DATA;
      end
      DATA: begin
        cnt_n = expire ? bit_reload : cnt - cw'(1);
        if (expire) begin
          sh_n = {rx_s, sh[7:1]};
          idx_n = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (idx == 3'd7) state_n = PARITY;
`else
          if (idx == 3'd7) state_n = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        cnt_n = expire ? bit_reload : cnt - cw'(1);
        if (expire) begin
          par_ok_n = !(^{sh, rx_s});
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        cnt_n = cnt - cw'(1);
        if (expire) begin
          state_n = rx_s ? IDLE : WAIT_HIGH;
          fe_n = !rx_s;
`ifdef UART_RX_PARITY_EN
          push = rx_s && par_ok;
          pe_n = rx_s && !par_ok;
`else
          push = rx_s;
`endif
        end
      end
      WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
      default: state_n = IDLE;
    endcase
  end
  // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + aw'(1);
      if (pop) rd_ptr <= rd_ptr + aw'(1);
      if (wr != pop) count <= wr ? count + aw1'(1) : count - aw1'(1);
    end
  end
  // FIFO storage, written with the completed byte on the stop-bit sample
  always_ff @(posedge Clk_i) begin
    if (wr) mem[wr_ptr] <= sh;
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver (clks_per_bit_p=16, fifo_depth_p=4)
module tb_uart_receiver;
  localparam int CPB = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  localparam int LAT = 3 + CPB / 2 + CPB * NB;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rd = 1'b0;
  logic [7:0] data;
  logic da, fe, ov, pe;
  int total = 0, passed = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  logic [7:0] q[$];
  logic [7:0] exp_b;

  uart_receiver #(.clks_per_bit_p(CPB), .fifo_depth_p(DEPTH)) dut (
    .Clk_i(clk), .Reset_i(rst), .Rx_i(rx), .Rd_En_i(rd), .Data_o(data),
    .Data_Available_o(da), .Frame_Error_o(fe), .Overflow_o(ov), .Parity_Error_o(pe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fe) fe_cnt <= fe_cnt + 1;
    if (ov) ov_cnt <= ov_cnt + 1;
    if (pe) pe_cnt <= pe_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic flip, input int hold);
    logic par;
    par = (^d) ^ flip;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    tick(CPB);
`endif
    rx = stop;
    tick(CPB + hold);
    rx = 1'b1;
  endtask

  task automatic pulse_rd;
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    total++; if (data !== 8'h00) $display("FAIL reset_data: got %h expected 00", data); else passed++;
    total++; if (da !== 1'b0) $display("FAIL reset_avail: got %b expected 0", da); else passed++;
    total++; if (fe !== 1'b0) $display("FAIL reset_fe: got %b expected 0", fe); else passed++;
    total++; if (ov !== 1'b0) $display("FAIL reset_ov: got %b expected 0", ov); else passed++;
    total++; if (pe !== 1'b0) $display("FAIL reset_pe: got %b expected 0", pe); else passed++;
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_back_to_back;
    int n;
    logic [7:0] first;
    n = 0;
    first = 8'h00;
    fork
      begin
        q.push_back(8'h55);
        send(8'h55, 1'b1, 1'b0, 0);
        q.push_back(8'hA3);
        send(8'hA3, 1'b1, 1'b0, 0);
      end
      begin
        @(negedge clk);
        while (!da && n < 2000) begin
          @(negedge clk);
          n++;
        end
        first = data;
      end
    join
    tick(4);
    total++; if (n != LAT) $display("FAIL b2b_latency: got %0d expected %0d", n, LAT); else passed++;
    total++; if (first !== 8'h55) $display("FAIL b2b_first_data: got %h expected 55", first); else passed++;
    while (q.size() > 0) begin
      exp_b = q.pop_front();
      total++; if (!da || data !== exp_b) $display("FAIL b2b_read: got %h avail %b expected %h", data, da, exp_b); else passed++;
      pulse_rd();
    end
    total++; if (da !== 1'b0) $display("FAIL b2b_empty: got %b expected 0", da); else passed++;
  endtask

  task automatic test_false_start;
    int f0, o0, p0;
    f0 = fe_cnt; o0 = ov_cnt; p0 = pe_cnt;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(3 * CPB);
    total++; if (da !== 1'b0) $display("FAIL glitch_avail: got %b expected 0", da); else passed++;
    total++; if (fe_cnt != f0 || ov_cnt != o0 || pe_cnt != p0)
      $display("FAIL glitch_flags: got fe%0d ov%0d pe%0d expected none", fe_cnt - f0, ov_cnt - o0, pe_cnt - p0); else passed++;
    q.push_back(8'h5A);
    send(8'h5A, 1'b1, 1'b0, 0);
    tick(4);
    exp_b = q.pop_front();
    total++; if (!da || data !== exp_b) $display("FAIL glitch_recover: got %h avail %b expected %h", data, da, exp_b); else passed++;
    pulse_rd();
  endtask

  task automatic test_frame_error;
    int f0;
    f0 = fe_cnt;
    fork
      send(8'h3C, 1'b0, 1'b0, 40);
      begin
        tick(LAT + 20);
        total++; if (fe_cnt - f0 != 1) $display("FAIL fe_pulse: got %0d expected 1", fe_cnt - f0); else passed++;
      end
    join
    tick(3 * CPB);
    total++; if (fe_cnt - f0 != 1) $display("FAIL fe_single: got %0d expected 1", fe_cnt - f0); else passed++;
    total++; if (da !== 1'b0) $display("FAIL fe_fifo: got %b expected 0", da); else passed++;
  endtask

  task automatic test_overflow;
    int o0;
    o0 = ov_cnt;
    for (int v = 1; v <= 5; v++) begin
      if (v <= DEPTH) q.push_back(8'(v));
      send(8'(v), 1'b1, 1'b0, 0);
    end
    tick(4);
    total++; if (ov_cnt - o0 != 1) $display("FAIL ovf_pulse: got %0d expected 1", ov_cnt - o0); else passed++;
    q.push_back(8'h06);
    fork
      send(8'h06, 1'b1, 1'b0, 0);
      begin
        tick(LAT - 1);
        exp_b = q.pop_front();
        total++; if (data !== exp_b) $display("FAIL ovf_coincident_read: got %h expected %h", data, exp_b); else passed++;
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
      end
    join
    tick(4);
    total++; if (ov_cnt - o0 != 1) $display("FAIL ovf_none_on_pop: got %0d expected 1", ov_cnt - o0); else passed++;
    while (q.size() > 0) begin
      exp_b = q.pop_front();
      total++; if (!da || data !== exp_b) $display("FAIL ovf_read: got %h avail %b expected %h", data, da, exp_b); else passed++;
      pulse_rd();
    end
    total++; if (da !== 1'b0) $display("FAIL ovf_empty: got %b expected 0", da); else passed++;
    pulse_rd();
    total++; if (da !== 1'b0 || data !== 8'h00) $display("FAIL empty_read: got %h avail %b expected 00 avail 0", data, da); else passed++;
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    d = 8'h7E;
    q.push_back(8'h99);
    send(8'h99, 1'b1, 1'b0, 0);
    tick(2);
    total++; if (da !== 1'b1) $display("FAIL rst_pre_avail: got %b expected 1", da); else passed++;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = d[4];
    tick(CPB / 2);
    rst = 1'b1;
    rx = 1'b1;
    tick(2);
    q.delete();
    total++; if (da !== 1'b0 || data !== 8'h00) $display("FAIL rst_mid_fifo: got %h avail %b expected 00 avail 0", data, da); else passed++;
    total++; if (fe !== 1'b0 || ov !== 1'b0 || pe !== 1'b0) $display("FAIL rst_mid_flags: got %b%b%b expected 000", fe, ov, pe); else passed++;
    rst = 1'b0;
    tick(3 * CPB);
    total++; if (da !== 1'b0) $display("FAIL rst_no_spurious: got %b expected 0", da); else passed++;
    q.push_back(8'h12);
    send(8'h12, 1'b1, 1'b0, 0);
    tick(4);
    exp_b = q.pop_front();
    total++; if (!da || data !== exp_b) $display("FAIL rst_next_frame: got %h avail %b expected %h", data, da, exp_b); else passed++;
    pulse_rd();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int p0;
    p0 = pe_cnt;
    q.push_back(8'h07);
    send(8'h07, 1'b1, 1'b0, 0);
    tick(4);
    total++; if (pe_cnt != p0) $display("FAIL par_good_flag: got %0d expected 0", pe_cnt - p0); else passed++;
    exp_b = q.pop_front();
    total++; if (!da || data !== exp_b) $display("FAIL par_good_data: got %h avail %b expected %h", data, da, exp_b); else passed++;
    pulse_rd();
    send(8'h07, 1'b1, 1'b1, 0);
    tick(4);
    total++; if (pe_cnt - p0 != 1) $display("FAIL par_bad_flag: got %0d expected 1", pe_cnt - p0); else passed++;
    total++; if (da !== 1'b0) $display("FAIL par_bad_drop: got %b expected 0", da); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_false_start();
    test_frame_error();
    test_overflow();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receive path for the board's UART link: the inbound counterpart of the existing UART transmitter, with the same baud timing and 8N1 framing. It deserialises bytes on `Rx_i`, checks the framing, and buffers good bytes in a show-ahead FIFO for a downstream command consumer. The consumer reads bytes through a simple read-enable interface.

## Interface
Parameters:
- `clks_per_bit_p`, 5208: clock cycles per UART bit (50 MHz / 9600 baud); minimum 8.
- `fifo_depth_p`, 16: receive FIFO depth in bytes; power of two, at least 2.

Ports:
- `Clk_i`  in  1: single system clock; every flop is on its rising edge.
- `Reset_i`  in  1: synchronous, active-high reset.
- `Rx_i`  in  1: asynchronous serial input; idle level is high.
- `Rd_En_i`  in  1: pops the FIFO head on a rising clock edge while `Data_Available_o`=1.
- `Data_o`  out  8: FIFO head byte; valid while `Data_Available_o`=1.
- `Data_Available_o`  out  1: FIFO is not empty.
- `Frame_Error_o`  out  1: one-cycle pulse when a stop bit is sampled low.
- `Overflow_o`  out  1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `Parity_Error_o`  out  1: one-cycle pulse on an even-parity mismatch. Tied to 0 when the parity feature is compiled out.

## Operation
- `Rx_i` passes through a 2-flop synchroniser. Both flops reset to 1. All receiver logic uses the synchronised value `rx_s`.
- FSM states: IDLE, START, DATA, PARITY (only when compiled in), STOP, WAIT_HIGH.
- IDLE:
  - When `rx_s`=0, load the bit counter with `clks_per_bit_p/2 - 1` and go to START.
- START:
  - At counter 0, resample `rx_s`.
  - If 1: false start, return to IDLE with no flag.
  - If 0: reload the counter with `clks_per_bit_p - 1` and go to DATA.
- DATA:
  - 8 samples, one each time the counter expires, reloading the counter after each.
  - Bits are shifted in LSB first.
  - After bit 7, go to PARITY, or to STOP if parity is compiled out.
- PARITY:
  - Take one sample.
  - The byte passes when XOR of the 8 data bits and the parity bit equals 0 (even parity).
  - Go to STOP.
- STOP, one sample:
  - `rx_s`=1 and parity OK: push the byte to the FIFO, or pulse `Overflow_o` if the FIFO is full. Go to IDLE.
  - `rx_s`=1 and parity bad: pulse `Parity_Error_o`, discard the byte, go to IDLE.
  - `rx_s`=0: pulse `Frame_Error_o`, discard the byte, go to WAIT_HIGH. A framing error takes priority over a parity error; only one flag pulses.
- WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This stops a break condition from retriggering reception.
- FIFO:
  - Circular buffer with read and write pointers of width log2(`fifo_depth_p`), plus an occupancy counter of width log2(`fifo_depth_p`)+1.
  - Pointers wrap modulo the depth.
  - Show-ahead: `Data_o` always drives `mem[rd_ptr]` when the FIFO is non-empty, and 0 when it is empty.
- Boundary rules:
  - `Rd_En_i` while empty is ignored. No pointer moves and no flag is raised.
  - Push and pop in the same cycle while full: both happen, the byte is accepted, no overflow, count unchanged.
  - Push and pop in the same cycle while non-empty: count unchanged.
  - `Reset_i` during a frame aborts it. The FSM returns to IDLE, the FIFO empties, and the partial byte is lost. A frame already in flight when reset releases is picked up only at its next falling edge.

## Timing
- Reset values: `Data_o`=0x00, `Data_Available_o`=0, `Frame_Error_o`=0, `Overflow_o`=0, `Parity_Error_o`=0. FSM in IDLE, counters and pointers at 0.
- Input latency: 2 cycles through the synchroniser.
- Start-edge-to-IDLE-exit response: 1 cycle.
- Bit sampling:
  - The start bit is sampled at the middle of the bit.
  - Each later bit is sampled exactly `clks_per_bit_p` cycles after the previous sample.
  - Sample points are within ±1 cycle of bit centre, measured at `Rx_i`.
- Push occurs on the cycle the stop bit is sampled. `Data_Available_o` and the new `Data_o` are visible on the next cycle.
- All error and overflow flags are registered, one cycle wide, and asserted on the cycle after the stop or parity sample.
- Pop: `Data_o` shows the next entry, and `Data_Available_o` updates, on the cycle after the `Rd_En_i` edge.
- Back-to-back frames are accepted with zero idle bits. The next start edge can be detected in the cycle after the stop sample.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - Frames are 8E1.
  - PARITY state is present.
  - Bytes with a parity mismatch are discarded and `Parity_Error_o` pulses.
- Undefined:
  - Frames are 8N1.
  - PARITY state is absent.
  - `Parity_Error_o` is constant 0.

## Test plan
- Bench uses `clks_per_bit_p`=16 and `fifo_depth_p`=4.
- 8N1 frame 0x55, then 0xA3 back to back with no idle bit -> FIFO holds 0x55 then 0xA3. `Data_o`=0x55 one cycle after the first stop sample. Two `Rd_En_i` pulses return 0xA3 and then `Data_Available_o`=0.
- Low glitch of 5 cycles on `Rx_i` -> false start. No FIFO write, no flags, FSM back in IDLE.
- Frame 0x3C with stop bit forced low, line held low for 40 cycles -> a single `Frame_Error_o` pulse, FIFO unchanged, no new reception until the line returns high.
- 5 frames 0x01 through 0x05 with no reads -> FIFO holds 0x01 to 0x04, one `Overflow_o` pulse on byte 5. Then a read coincident with a 6th push while full -> 0x06 is accepted and no overflow.
- `Reset_i` pulsed during data bit 4 of frame 0x7E -> all outputs return to reset values. The next clean frame 0x12 is received correctly.
- With `UART_RX_PARITY_EN`: frame 0x07 with parity bit 1 -> byte stored. Frame 0x07 with parity bit 0 -> `Parity_Error_o` pulses and the byte is discarded.
